// File: rtl/punc_datapath.sv
`timescale 1ns/1ps
// PUnC LC3 datapath: PC, IR, 8x16 register file, NZP flags and a unified word-addressed memory.
// Every cycle it executes the control word supplied by the control unit.
module punc_datapath #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_inc,
  input  logic        pc_w_en,
  input  logic        pc_clr,
  input  logic        ir_w_en,
  input  logic [15:0] mem_r_addr_ctrl,
  input  logic [1:0]  mem_r_s,
  input  logic [1:0]  mem_w_addr_s,
  input  logic [1:0]  mem_w_data_s,
  input  logic        mem_w_en,
  input  logic [4:0]  alu_s,
  input  logic        rf_w_en,
  input  logic [1:0]  rf_w_s,
  input  logic [2:0]  rf_w_addr,
  input  logic [15:0] rf_w_data_ctrl,
  input  logic [2:0]  rf_r0_addr,
  input  logic [2:0]  rf_r1_addr,
  input  logic        status_w_en,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_rf_addr,
  input  logic [15:0] dbg_mem_addr,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [2:0]  nzp,
  output logic [15:0] dbg_rf_data,
  output logic [15:0] dbg_mem_data
);
  localparam int MEM_DEPTH = 1 << MEM_AW;

  logic [15:0] mem_q [0:MEM_DEPTH-1];
  logic [15:0] rf_q  [0:7];
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q;
  logic [15:0] sti_addr_q;
  logic [2:0]  nzp_q, nzp_d;

  logic [15:0] r0_data, r1_data;
  logic [15:0] imm5_sx, off6_sx, off9_sx, off11_sx;
  logic [15:0] alu_out;
  logic [15:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;
  logic [15:0] rf_w_data;
  logic        br_taken;

  assign r0_data  = rf_q[rf_r0_addr];
  assign r1_data  = rf_q[rf_r1_addr];
  assign imm5_sx  = {{11{ir_q[4]}}, ir_q[4:0]};
  assign off6_sx  = {{10{ir_q[5]}}, ir_q[5:0]};
  assign off9_sx  = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11_sx = {{5{ir_q[10]}}, ir_q[10:0]};

  always_comb begin
    alu_out = '0;
    case (alu_s)
      5'd0:                                  alu_out = r0_data + r1_data;
      5'd1:                                  alu_out = r0_data + imm5_sx;
      5'd2:                                  alu_out = r0_data & r1_data;
      5'd3:                                  alu_out = r0_data & imm5_sx;
      5'd4, 5'd8, 5'd9, 5'd12, 5'd14, 5'd15: alu_out = pc_q + off9_sx;
      5'd5, 5'd7, 5'd10:                     alu_out = r0_data;
      5'd6:                                  alu_out = pc_q + off11_sx;
      5'd11:                                 alu_out = r0_data + off6_sx;
      5'd13:                                 alu_out = ~r0_data;
      5'd16:                                 alu_out = r1_data + off6_sx;
      default:                               alu_out = '0;
    endcase
  end

  // Memory: asynchronous read, all addresses truncated to MEM_AW bits.
  assign mem_r_addr = (mem_r_s == 2'd0) ? mem_r_addr_ctrl : alu_out;
  assign mem_r_data = mem_q[mem_r_addr[MEM_AW-1:0]];
  assign mem_w_addr = (mem_w_addr_s == 2'd1) ? sti_addr_q : alu_out;
  assign mem_w_data = r0_data;

  // Program load stays live through reset so a bench can preload while held.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr[MEM_AW-1:0]] <= ld_data;
    end else if (mem_w_en && !rst) begin
      mem_q[mem_w_addr[MEM_AW-1:0]] <= mem_w_data;
    end
  end

  always_comb begin
    rf_w_data = alu_out;
    case (rf_w_s)
      2'd0:    rf_w_data = alu_out;
      2'd1:    rf_w_data = mem_r_data;
      2'd2:    rf_w_data = pc_q;
      default: rf_w_data = rf_w_data_ctrl;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_w_en) begin
      rf_q[rf_w_addr] <= rf_w_data;
    end
  end

  always_comb begin
    nzp_d = nzp_q;
    if (status_w_en) begin
      nzp_d = {rf_w_data[15], rf_w_data == 16'd0, !rf_w_data[15] && (rf_w_data != 16'd0)};
    end
  end

  // A BR whose condition fails holds the PC instead of falling through to pc_inc.
  assign br_taken = |(ir_q[11:9] & nzp_q);

  always_comb begin
    pc_d = pc_q;
    if (pc_clr) begin
      pc_d = '0;
    end else if (pc_w_en) begin
      if ((alu_s != 5'd4) || br_taken) pc_d = alu_out;
    end else if (pc_inc) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      nzp_q      <= 3'b010;
      sti_addr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      nzp_q <= nzp_d;
      if (ir_w_en)          ir_q       <= mem_r_data;
      if (alu_s == 5'd15)   sti_addr_q <= mem_r_data;
    end
  end

  assign pc           = pc_q;
  assign ir           = ir_q;
  assign nzp          = nzp_q;
  assign dbg_rf_data  = rf_q[dbg_rf_addr];
  assign dbg_mem_data = mem_q[dbg_mem_addr[MEM_AW-1:0]];

  generate
    if (MEM_AW < 16) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^{mem_w_data_s, ld_addr[15:MEM_AW], dbg_mem_addr[15:MEM_AW],
                             mem_r_addr[15:MEM_AW], mem_w_addr[15:MEM_AW]};
    end else begin : g_unused_full
      logic unused_bits;
      assign unused_bits = ^mem_w_data_s;
    end
  endgenerate

endmodule

// File: tb/tb_punc_datapath.sv
`timescale 1ns/1ps
// Scoreboard bench for punc_datapath: stimulus acts as an LC3 control unit and pushes
// expectations from an instruction-level model; a monitor pops and compares on negedge.
module tb_punc_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_inc, pc_w_en, pc_clr, ir_w_en;
  logic [15:0] mem_r_addr_ctrl;
  logic [1:0]  mem_r_s, mem_w_addr_s, mem_w_data_s;
  logic        mem_w_en;
  logic [4:0]  alu_s;
  logic        rf_w_en;
  logic [1:0]  rf_w_s;
  logic [2:0]  rf_w_addr;
  logic [15:0] rf_w_data_ctrl;
  logic [2:0]  rf_r0_addr, rf_r1_addr;
  logic        status_w_en;
  logic        ld_en;
  logic [15:0] ld_addr, ld_data;
  logic [2:0]  dbg_rf_addr = 3'd0;
  logic [15:0] dbg_mem_addr = 16'd0;
  logic [15:0] pc, ir;
  logic [2:0]  nzp;
  logic [15:0] dbg_rf_data, dbg_mem_data;

  punc_datapath #(.MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .pc_inc(pc_inc), .pc_w_en(pc_w_en), .pc_clr(pc_clr),
    .ir_w_en(ir_w_en), .mem_r_addr_ctrl(mem_r_addr_ctrl), .mem_r_s(mem_r_s),
    .mem_w_addr_s(mem_w_addr_s), .mem_w_data_s(mem_w_data_s), .mem_w_en(mem_w_en),
    .alu_s(alu_s), .rf_w_en(rf_w_en), .rf_w_s(rf_w_s), .rf_w_addr(rf_w_addr),
    .rf_w_data_ctrl(rf_w_data_ctrl), .rf_r0_addr(rf_r0_addr), .rf_r1_addr(rf_r1_addr),
    .status_w_en(status_w_en), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_rf_addr(dbg_rf_addr), .dbg_mem_addr(dbg_mem_addr), .pc(pc), .ir(ir), .nzp(nzp),
    .dbg_rf_data(dbg_rf_data), .dbg_mem_data(dbg_mem_data)
  );

  always #5 clk = ~clk;

  localparam int K_PC = 0, K_IR = 1, K_NZP = 2, K_RF = 3, K_MEM = 4;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req  = 1'b0;
  logic done_req = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Instruction-level reference state.
  logic [15:0] m_mem [0:255];
  logic [15:0] m_rf  [0:7];
  logic [15:0] m_pc, m_ir;
  logic [2:0]  m_nzp;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v;
    for (int i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

  function automatic logic [2:0] cc(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  // Monitor: pops one expectation per requested check.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_req) begin
        exp_t e;
        logic [15:0] act;
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: got no expectation, required one");
        end else begin
          e = sb_q.pop_front();
          case (e.kind)
            K_PC:    act = pc;
            K_IR:    act = ir;
            K_NZP:   act = {13'd0, nzp};
            K_RF:    act = dbg_rf_data;
            default: act = dbg_mem_data;
          endcase
          if (act !== e.val) begin
            bad++;
            $display("FAIL %s: got %h required %h", e.name, act, e.val);
          end
        end
      end
      if (done_req) begin
        total++;
        if (sb_q.size() != 0) begin
          bad++;
          $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic idle();
    pc_inc = 0; pc_w_en = 0; pc_clr = 0; ir_w_en = 0; mem_r_addr_ctrl = 0; mem_r_s = 0;
    mem_w_addr_s = 0; mem_w_data_s = 0; mem_w_en = 0; alu_s = 0; rf_w_en = 0; rf_w_s = 0;
    rf_w_addr = 0; rf_w_data_ctrl = 0; rf_r0_addr = 0; rf_r1_addr = 0; status_w_en = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_val(input int kind, input logic [15:0] addr, input logic [15:0] val,
                            input string name);
    exp_t e;
    e.kind = kind; e.addr = addr; e.val = val; e.name = name;
    sb_q.push_back(e);
    dbg_rf_addr  = addr[2:0];
    dbg_mem_addr = addr;
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    m_mem[a[7:0]] = d;
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
    rf_w_en = 1; rf_w_s = 2'd3; rf_w_addr = r; rf_w_data_ctrl = v;
    step();
    m_rf[r] = v;
  endtask

  task automatic set_pc(input int v);
    pc_clr = 1;
    step();
    repeat (v) begin
      pc_inc = 1;
      step();
    end
    m_pc = 16'(v);
  endtask

  // Place instr at the current PC, fetch it, then drive its execute cycles.
  task automatic run(input logic [15:0] instr);
    logic [3:0]  op;
    logic [15:0] a, b, t;
    load(m_pc, instr);
    mem_r_s = 0; mem_r_addr_ctrl = m_pc; ir_w_en = 1; pc_inc = 1;
    step();
    m_ir = instr;
    m_pc = m_pc + 16'd1;
    op = instr[15:12];
    case (op)
      4'h1, 4'h5: begin
        alu_s = ((op == 4'h1) ? 5'd0 : 5'd2) + {4'd0, instr[5]};
        rf_r0_addr = instr[8:6]; rf_r1_addr = instr[2:0];
        rf_w_en = 1; rf_w_s = 0; rf_w_addr = instr[11:9]; status_w_en = 1;
        step();
        a = m_rf[instr[8:6]];
        b = instr[5] ? sx({11'd0, instr[4:0]}, 5) : m_rf[instr[2:0]];
        t = (op == 4'h1) ? a + b : a & b;
        m_rf[instr[11:9]] = t;
        m_nzp = cc(t);
      end
      4'h9: begin
        alu_s = 5'd13; rf_r0_addr = instr[8:6];
        rf_w_en = 1; rf_w_s = 0; rf_w_addr = instr[11:9]; status_w_en = 1;
        step();
        t = ~m_rf[instr[8:6]];
        m_rf[instr[11:9]] = t;
        m_nzp = cc(t);
      end
      4'h0: begin
        pc_w_en = 1; pc_inc = 1; alu_s = 5'd4;
        step();
        if ((instr[11:9] & m_nzp) != 3'd0) m_pc = m_pc + sx({7'd0, instr[8:0]}, 9);
      end
      4'hA: begin
        alu_s = 5'd9; mem_r_s = 1; rf_w_en = 1; rf_w_s = 1; rf_w_addr = instr[11:9];
        step();
        alu_s = 5'd5; rf_r0_addr = instr[11:9]; mem_r_s = 1;
        rf_w_en = 1; rf_w_s = 1; rf_w_addr = instr[11:9]; status_w_en = 1;
        step();
        a = m_pc + sx({7'd0, instr[8:0]}, 9);
        t = m_mem[m_mem[a[7:0]][7:0]];
        m_rf[instr[11:9]] = t;
        m_nzp = cc(t);
      end
      4'hB: begin
        alu_s = 5'd15; mem_r_s = 1;
        step();
        mem_w_addr_s = 1; mem_w_en = 1; rf_r0_addr = instr[11:9];
        step();
        a = m_pc + sx({7'd0, instr[8:0]}, 9);
        m_mem[m_mem[a[7:0]][7:0]] = m_rf[instr[11:9]];
      end
      4'h4: begin
        alu_s = 5'd6; pc_w_en = 1; rf_w_en = 1; rf_w_addr = 3'd7; rf_w_s = 2;
        step();
        t = m_pc;
        m_pc = m_pc + sx({5'd0, instr[10:0]}, 11);
        m_rf[7] = t;
      end
      default: begin
        alu_s = 5'd5; rf_r0_addr = instr[8:6]; pc_w_en = 1;
        step();
        m_pc = m_rf[instr[8:6]];
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] instr, a16, d16;
    logic [2:0]  dr, s1, s2;
    logic [8:0]  off9;
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    m_pc = 0; m_ir = 0; m_nzp = 3'b010;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;

    expect_val(K_PC, 0, 16'h0000, "rst_pc");
    expect_val(K_IR, 0, 16'h0000, "rst_ir");
    expect_val(K_NZP, 0, 16'h0002, "rst_nzp");
    for (int i = 0; i < 8; i++) expect_val(K_RF, 16'(i), 16'h0000, "rst_rf");

    // ADD R1,R1,#1 at address 0
    run(16'h1261);
    expect_val(K_RF, 1, 16'h0001, "add_r1");
    expect_val(K_NZP, 0, 16'h0001, "add_nzp");
    expect_val(K_PC, 0, 16'h0001, "add_pc");
    expect_val(K_IR, 0, 16'h1261, "add_ir");

    // AND R3,R2,R2 with R2=0x8000, then BRn / BRz at address 5
    set_reg(2, 16'h8000);
    run(16'h5682);
    expect_val(K_RF, 3, 16'h8000, "and_r3");
    expect_val(K_NZP, 0, 16'h0004, "and_nzp");
    set_pc(5);
    run(16'h0803);
    expect_val(K_PC, 0, 16'h0009, "brn_taken");
    set_pc(5);
    run(16'h0403);
    expect_val(K_PC, 0, 16'h0006, "brz_hold");

    // LDI R4 at 0x10, off9=1
    load(16'h0012, 16'h0040);
    load(16'h0040, 16'hBEEF);
    set_pc(16'h10);
    run(16'hA801);
    expect_val(K_RF, 4, 16'hBEEF, "ldi_r4");
    expect_val(K_NZP, 0, 16'h0004, "ldi_nzp");

    // STI R5 at 0x1E, off9=1 -> pointer at 0x20
    load(16'h0020, 16'h0050);
    set_reg(5, 16'h1234);
    set_pc(16'h1E);
    run(16'hBA01);
    expect_val(K_MEM, 16'h0050, 16'h1234, "sti_target");
    expect_val(K_MEM, 16'h0020, 16'h0050, "sti_ptr");

    // JSR -2 at 0x30, then JMP R7
    set_pc(16'h30);
    run(16'h4FFE);
    expect_val(K_RF, 7, 16'h0031, "jsr_r7");
    expect_val(K_PC, 0, 16'h002F, "jsr_pc");
    run(16'hC1C0);
    expect_val(K_PC, 0, 16'h0031, "jmp_pc");

    // PC priority and wrap at 0xFFFF
    set_reg(0, 16'hFFFF);
    alu_s = 5'd5; rf_r0_addr = 0; pc_w_en = 1;
    step();
    expect_val(K_PC, 0, 16'hFFFF, "pc_load_ffff");
    alu_s = 5'd5; rf_r0_addr = 0; pc_w_en = 1; pc_clr = 1; pc_inc = 1;
    step();
    expect_val(K_PC, 0, 16'h0000, "pc_clr_prio");
    alu_s = 5'd5; rf_r0_addr = 0; pc_w_en = 1;
    step();
    pc_inc = 1;
    step();
    expect_val(K_PC, 0, 16'h0000, "pc_inc_wrap");

    // Status update without an RF write
    status_w_en = 1; rf_w_s = 2'd3; rf_w_data_ctrl = 16'h0000;
    step();
    expect_val(K_NZP, 0, 16'h0002, "nzp_no_rfw");
    expect_val(K_RF, 0, 16'hFFFF, "nzp_no_rfw_r0");

    // ld_en beats mem_w_en at the same address
    set_reg(0, 16'h0060);
    ld_en = 1; ld_addr = 16'h0060; ld_data = 16'h7777;
    mem_w_en = 1; mem_w_addr_s = 0; alu_s = 5'd5; rf_r0_addr = 0;
    step();
    m_mem[8'h60] = 16'h7777;
    expect_val(K_MEM, 16'h0060, 16'h7777, "ld_prio");

    // Randomized ALU/BR instructions plus truncated-address loads
    set_pc(16'h80);
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      dr = 3'($urandom); s1 = 3'($urandom); s2 = 3'($urandom);
      off9 = 9'($urandom_range(0, 31)) - 9'd16;
      case ($urandom_range(0, 3))
        0:       instr = $urandom_range(0, 1) ? {4'h1, dr, s1, 1'b1, 5'($urandom)}
                                              : {4'h1, dr, s1, 3'b000, s2};
        1:       instr = $urandom_range(0, 1) ? {4'h5, dr, s1, 1'b1, 5'($urandom)}
                                              : {4'h5, dr, s1, 3'b000, s2};
        2:       instr = {4'h9, dr, s1, 6'h3F};
        default: instr = {4'h0, 3'($urandom), off9};
      endcase
      run(instr);
      if (instr[15:12] != 4'h0) expect_val(K_RF, {13'd0, instr[11:9]}, m_rf[instr[11:9]], "rnd_rf");
      expect_val(K_NZP, 0, {13'd0, m_nzp}, "rnd_nzp");
      expect_val(K_PC, 0, m_pc, "rnd_pc");
      if ($urandom_range(0, 3) == 0) begin
        a16 = 16'($urandom); d16 = 16'($urandom);
        load(a16, d16);
        expect_val(K_MEM, {~a16[15:8], a16[7:0]}, m_mem[a16[7:0]], "rnd_mem_trunc");
      end
    end

    // Reset mid-instruction: pending writes dropped except the program load
    set_reg(1, 16'h0071);
    load(16'h0071, 16'h5555);
    rst = 1;
    rf_w_en = 1; rf_w_s = 2'd3; rf_w_addr = 1; rf_w_data_ctrl = 16'h4444; status_w_en = 1;
    pc_inc = 1; ir_w_en = 1; mem_w_en = 1; alu_s = 5'd5; rf_r0_addr = 1;
    ld_en = 1; ld_addr = 16'h0070; ld_data = 16'hABCD;
    step();
    rst = 0;
    m_mem[8'h70] = 16'hABCD;
    expect_val(K_RF, 1, 16'h0000, "rst_mid_rf");
    expect_val(K_PC, 0, 16'h0000, "rst_mid_pc");
    expect_val(K_NZP, 0, 16'h0002, "rst_mid_nzp");
    expect_val(K_MEM, 16'h0070, m_mem[8'h70], "rst_mid_ld");
    expect_val(K_MEM, 16'h0071, m_mem[8'h71], "rst_mid_nowr");

    done_req = 1'b1;
  end

endmodule
